// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths and per-register scoreboard status for the register file.
package reg_file_pkg;
  localparam int COMMON_WIDTH = 32;
  localparam int XLEN = COMMON_WIDTH;
  localparam int NREG = 32;
  localparam int REG_W = $clog2(NREG);
  localparam int TAG_W = 4;
  typedef struct packed {
    logic busy;
    logic [TAG_W-1:0] tag;
  } reg_status_t;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: decoder-to-register-file request/operand bundle.
interface reg_file_if;
  import reg_file_pkg::*;
  logic issue_valid;
  logic rs1_en;
  logic rs2_en;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic rd_en;
  logic [REG_W-1:0] rd;
  logic [TAG_W-1:0] issue_tag;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic rs1_busy;
  logic rs2_busy;
  logic [TAG_W-1:0] rs1_tag;
  logic [TAG_W-1:0] rs2_tag;
  modport master (
    output issue_valid, rs1_en, rs2_en, rs1, rs2, rd_en, rd, issue_tag,
    input rs1_data, rs2_data, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
  modport slave (
    input issue_valid, rs1_en, rs2_en, rs1, rs2, rd_en, rd, issue_tag,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: one source operand mux with writeback bypass.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  logic                      rst,
  input  logic                      en,
  input  logic [REG_W-1:0]          idx,
  input  logic [NREG-1:0][XLEN-1:0] data_arr,
  input  reg_status_t [NREG-1:0]    stat_arr,
  input  logic                      wb_en,
  input  logic [REG_W-1:0]          wb_rd,
  input  logic [TAG_W-1:0]          wb_tag,
  input  logic [XLEN-1:0]           wb_data,
  output logic [XLEN-1:0]           data,
  output logic                      busy,
  output logic [TAG_W-1:0]          tag
);
  reg_status_t st;
  logic live;
  logic byp;
  always_comb begin
    st = stat_arr[idx];
    live = en && idx != '0;
    byp = live && wb_en && wb_rd == idx && st.busy && wb_tag == st.tag;
    // while in reset only a same-cycle bypass may drive a nonzero value
    data = byp ? wb_data : (live && !rst) ? data_arr[idx] : '0;
    busy = live && !rst && st.busy && !byp;
    tag = (live && !rst) ? st.tag : '0;
  end
endmodule

// File: rtl/reg_file.sv
// reg_file: architectural registers with busy/tag scoreboard, issue marking and writeback retire.
module reg_file
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  reg_file_if.slave         dec,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush
);
  logic [NREG-1:0][XLEN-1:0] data_q, data_d;
  reg_status_t [NREG-1:0] stat_q, stat_d;
  logic wb_hit;
  logic iss;
  assign wb_hit = wb_en && wb_rd != '0;
  assign iss = dec.issue_valid && dec.rd_en && dec.rd != '0 && !flush;
  always_comb begin
    data_d = data_q;
    stat_d = stat_q;
    if (wb_hit) begin
      data_d[wb_rd] = wb_data;
      if (stat_q[wb_rd].busy && stat_q[wb_rd].tag == wb_tag) stat_d[wb_rd].busy = 1'b0;
    end
    // issue overrides a same-register retire so the newer producer stays pending
    if (iss) stat_d[dec.rd] = '{busy: 1'b1, tag: dec.issue_tag};
    if (flush) for (int i = 0; i < NREG; i++) stat_d[i].busy = 1'b0;
  end
  always_ff @(posedge clk) begin
    data_q <= rst ? '0 : data_d;
    stat_q <= rst ? '0 : stat_d;
  end
  reg_file_read_port u_rs1 (
    .rst(rst), .en(dec.rs1_en), .idx(dec.rs1), .data_arr(data_q), .stat_arr(stat_q),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_tag(wb_tag), .wb_data(wb_data),
    .data(dec.rs1_data), .busy(dec.rs1_busy), .tag(dec.rs1_tag)
  );
  reg_file_read_port u_rs2 (
    .rst(rst), .en(dec.rs2_en), .idx(dec.rs2), .data_arr(data_q), .stat_arr(stat_q),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_tag(wb_tag), .wb_data(wb_data),
    .data(dec.rs2_data), .busy(dec.rs2_busy), .tag(dec.rs2_tag)
  );
endmodule
